// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load)
// with an autonomous burst engine that shifts a programmed number of positions.
//
// state | meaning
// IDLE  | manual mode ops active; waits for a burst start
// SHIFT | burst running; one shift per enabled edge until count reaches 0
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic             dir,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_clamped;

  assign len_clamped = (len > WIDTH_L) ? WIDTH_L : len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // q is deliberately untouched on the accepting edge
            dir_d = dir;
            cnt_d = len_clamped;
            if (len_clamped != '0) begin
              state_d = SHIFT;
              busy_d  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            unique case (mode)
              2'b01:   q_d = {sin_r, q_q[WIDTH-1:1]};
              2'b10:   q_d = {q_q[WIDTH-2:0], sin_l};
              2'b11:   q_d = pdata;
              default: q_d = q_q;
            endcase
          end
        end
        SHIFT: begin
          q_d   = dir_q ? {q_q[WIDTH-2:0], sin_l} : {sin_r, q_q[WIDTH-1:1]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8): manual ops, bursts,
// length clamp, stall/ignore behaviour and reset mid-burst.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdata;
  logic             start;
  logic             dir;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pdata  (pdata),
    .start  (start),
    .dir    (dir),
    .len    (len),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q  [3];
  logic       exp_so [3];
  logic [7:0] ones;

  initial begin
    exp_q  = '{8'h40, 8'h20, 8'h10};
    exp_so = '{1'b1, 1'b0, 1'b0};

    // reset dominates en=0 and a pending start
    rst = 1'b1; en = 1'b0; start = 1'b1; mode = 2'b00;
    sin_r = 1'b0; sin_l = 1'b0; pdata = '0; dir = 1'b0; len = '0;
    tick(); tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0; start = 1'b0; en = 1'b1;

    // manual ops
    mode = 2'b11; pdata = 8'hA5; tick();
    check("load_a5", 32'(q), 32'hA5);
    mode = 2'b01; sin_r = 1'b1; tick();
    check("shr_d2", 32'(q), 32'hD2);
    mode = 2'b10; sin_l = 1'b0; tick();
    check("shl_a4", 32'(q), 32'hA4);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_a4", 32'(q), 32'hA4);
      check("hold_done", 32'(done), 32'h0);
    end

    // burst right, len=3
    mode = 2'b11; pdata = 8'h81; tick();
    mode = 2'b01; sin_r = 1'b0; start = 1'b1; dir = 1'b0; len = 4'd3;
    tick();
    check("br_start_q", 32'(q), 32'h81);
    check("br_start_busy", 32'(busy), 32'h1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("br_sout_r", 32'(sout_r), 32'(exp_so[i]));
      tick();
      check("br_q", 32'(q), 32'(exp_q[i]));
      check("br_busy", 32'(busy), (i < 2) ? 32'h1 : 32'h0);
      check("br_done", 32'(done), (i < 2) ? 32'h0 : 32'h1);
    end
    mode = 2'b00;
    tick();
    check("br_done_clr", 32'(done), 32'h0);

    // len=0: immediate done, no shift
    start = 1'b1; len = 4'd0; tick();
    check("l0_busy", 32'(busy), 32'h0);
    check("l0_done", 32'(done), 32'h1);
    check("l0_q", 32'(q), 32'h10);
    start = 1'b0; tick();
    check("l0_done_clr", 32'(done), 32'h0);

    // len=12 clamps to 8 shifts left
    mode = 2'b11; pdata = 8'h00; tick();
    mode = 2'b00; start = 1'b1; dir = 1'b1; len = 4'd12; sin_l = 1'b1;
    tick();
    check("lc_busy0", 32'(busy), 32'h1);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ones = 8'((9'd1 << k) - 9'd1);
      check("lc_q", 32'(q), 32'(ones));
      check("lc_busy", 32'(busy), (k < 8) ? 32'h1 : 32'h0);
      check("lc_done", 32'(done), (k < 8) ? 32'h0 : 32'h1);
    end
    tick();
    check("lc_done_clr", 32'(done), 32'h0);

    // stall with en=0 and ignored start/mode mid-burst
    start = 1'b1; dir = 1'b0; len = 4'd4; sin_r = 1'b0; tick();
    start = 1'b0;
    tick(); check("st_q1", 32'(q), 32'h7F);
    tick(); check("st_q2", 32'(q), 32'h3F);
    en = 1'b0; start = 1'b1; mode = 2'b11; pdata = 8'h55; dir = 1'b1; len = 4'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("st_frz_q", 32'(q), 32'h3F);
      check("st_frz_busy", 32'(busy), 32'h1);
      check("st_frz_done", 32'(done), 32'h0);
    end
    en = 1'b1;
    tick(); check("st_q3", 32'(q), 32'h1F);
    check("st_busy3", 32'(busy), 32'h1);
    start = 1'b0; mode = 2'b00;
    tick(); check("st_q4", 32'(q), 32'h0F);
    check("st_busy4", 32'(busy), 32'h0);
    check("st_done4", 32'(done), 32'h1);
    en = 1'b0; tick();
    check("st_en0_done", 32'(done), 32'h0);
    check("st_en0_q", 32'(q), 32'h0F);
    en = 1'b1;

    // reset mid-burst, then fresh burst
    mode = 2'b11; pdata = 8'hF0; tick();
    mode = 2'b00; start = 1'b1; dir = 1'b0; len = 4'd5; sin_r = 1'b1; tick();
    start = 1'b0;
    tick(); check("rm_q1", 32'(q), 32'hF8);
    tick(); check("rm_q2", 32'(q), 32'hFC);
    rst = 1'b1; tick();
    check("rm_q", 32'(q), 32'h00);
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_done", 32'(done), 32'h0);
    rst = 1'b0; start = 1'b1; dir = 1'b1; len = 4'd2; sin_l = 1'b1; tick();
    check("rm_new_busy", 32'(busy), 32'h1);
    check("rm_new_done", 32'(done), 32'h0);
    check("rm_new_q0", 32'(q), 32'h00);
    start = 1'b0;
    tick(); check("rm_new_q1", 32'(q), 32'h01);
    tick(); check("rm_new_q2", 32'(q), 32'h03);
    check("rm_new_done2", 32'(done), 32'h1);
    check("rm_new_busy2", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
